// File: rtl/fft_consts_pkg.sv
// Shared fixed-point constants, complex sample type and saturation helpers
// used by the IFFT/FFT datapath blocks.
package fft_consts;

  localparam int FP_BITS   = 16;
  localparam int FRAC_BITS = 14;
  localparam int WIDE_BITS = 2 * FP_BITS + 1;

  typedef struct packed {
    logic signed [FP_BITS-1:0] r;
    logic signed [FP_BITS-1:0] i;
  } complex_t;

  localparam logic signed [FP_BITS-1:0] FP_MAX = {1'b0, {(FP_BITS-1){1'b1}}};
  localparam logic signed [FP_BITS-1:0] FP_MIN = {1'b1, {(FP_BITS-1){1'b0}}};

  function automatic logic signed [FP_BITS-1:0] sat_fp(
    input  logic signed [WIDE_BITS-1:0] v,
    output logic                        clamped
  );
    logic signed [FP_BITS-1:0] res;
    clamped = 1'b0;
    res     = v[FP_BITS-1:0];
    if (v > WIDE_BITS'(FP_MAX)) begin
      res     = FP_MAX;
      clamped = 1'b1;
    end else if (v < WIDE_BITS'(FP_MIN)) begin
      res     = FP_MIN;
      clamped = 1'b1;
    end
    return res;
  endfunction

  // Negating the most negative value has no representation; pin it to FP_MAX.
  function automatic complex_t cplx_conj(input complex_t w, output logic clamped);
    complex_t c;
    clamped = (w.i == FP_MIN);
    c.r     = w.r;
    c.i     = clamped ? FP_MAX : -w.i;
    return c;
  endfunction

endpackage

// File: rtl/ibfu_gs_if.sv
// Handshake bundle for the inverse butterfly: X/Y/W in, A/B out.
interface ibfu_gs_if;
  import fft_consts::*;

  // Valid/ready: a beat transfers on a rising clk edge where valid && ready.
  // The source holds its payload stable while valid && !ready; ready never
  // depends on valid of the same channel.
  logic     in_valid;
  logic     in_ready;
  complex_t X_in;
  complex_t Y_in;
  complex_t W_in;
  logic     out_valid;
  logic     out_ready;
  complex_t A_out;
  complex_t B_out;

  modport master (
    output in_valid, X_in, Y_in, W_in, out_ready,
    input  in_ready, out_valid, A_out, B_out
  );

  modport slave (
    input  in_valid, X_in, Y_in, W_in, out_ready,
    output in_ready, out_valid, A_out, B_out
  );
endinterface

// File: rtl/ibfu_gs_mul.sv
// Registered four-multiplier complex product; conj_b selects a*conj(b).
module cplx_mul_wide
  import fft_consts::*;
(
  input  logic                        clk,
  input  logic                        en,
  input  logic                        conj_b,
  input  complex_t                    a,
  input  complex_t                    b,
  output logic signed [WIDE_BITS-1:0] p_r,
  output logic signed [WIDE_BITS-1:0] p_i
);
  localparam int PROD_BITS = 2 * FP_BITS;

  logic signed [PROD_BITS-1:0] rr, ii, ri, ir;

  assign rr = PROD_BITS'($signed(a.r)) * PROD_BITS'($signed(b.r));
  assign ii = PROD_BITS'($signed(a.i)) * PROD_BITS'($signed(b.i));
  assign ri = PROD_BITS'($signed(a.r)) * PROD_BITS'($signed(b.i));
  assign ir = PROD_BITS'($signed(a.i)) * PROD_BITS'($signed(b.r));

  // Conjugation is folded into the add/sub signs so b.i is never negated.
  always_ff @(posedge clk) begin
    if (en) begin
      p_r <= conj_b ? (WIDE_BITS'(rr) + WIDE_BITS'(ii)) : (WIDE_BITS'(rr) - WIDE_BITS'(ii));
      p_i <= conj_b ? (WIDE_BITS'(ir) - WIDE_BITS'(ri)) : (WIDE_BITS'(ri) + WIDE_BITS'(ir));
    end
  end

endmodule

// File: rtl/ibfu_gs.sv
// Four-stage radix-2 Gentleman-Sande inverse butterfly with valid/ready
// stalling: A = (X+Y)/2, B = ((X-Y)/2) * conj(W).
module ibfu_gs
  import fft_consts::*;
#(
  parameter bit HALVE    = 1'b1,
  parameter bit SATURATE = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  ibfu_gs_if.slave bus,
  output logic     ovf,
  input  logic     ovf_clr
);
  localparam int SUM_BITS = FP_BITS + 1;

  logic     adv;
  logic     v1, v2, v3, v4;
  complex_t x1, y1, w1;
  complex_t s2, d2, cw2, s3;
  complex_t a4, b4;
  logic signed [WIDE_BITS-1:0] p3_r, p3_i;

  // The whole pipe moves together; a stalled output freezes every stage.
  assign adv           = !v4 || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = v4;
  assign bus.A_out     = a4;
  assign bus.B_out     = b4;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      v4 <= 1'b0;
    end else if (adv) begin
      v1 <= bus.in_valid;
      v2 <= v1;
      v3 <= v2;
      v4 <= v3;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      x1 <= bus.X_in;
      y1 <= bus.Y_in;
      w1 <= bus.W_in;
    end
  end

  logic signed [SUM_BITS-1:0] sum_r, sum_i, dif_r, dif_i;
  complex_t s2_d, d2_d, cw2_d;
  logic [3:0] c_sd;
  logic       c_cw;
  logic       s2_clamp;

  // A halved value always fits, so sat_fp only ever flags in the HALVE=0 case.
  always_comb begin
    c_sd   = 4'b0000;
    c_cw   = 1'b0;
    sum_r  = SUM_BITS'($signed(x1.r)) + SUM_BITS'($signed(y1.r));
    sum_i  = SUM_BITS'($signed(x1.i)) + SUM_BITS'($signed(y1.i));
    dif_r  = SUM_BITS'($signed(x1.r)) - SUM_BITS'($signed(y1.r));
    dif_i  = SUM_BITS'($signed(x1.i)) - SUM_BITS'($signed(y1.i));
    s2_d.r = sat_fp(WIDE_BITS'(HALVE ? (sum_r >>> 1) : sum_r), c_sd[0]);
    s2_d.i = sat_fp(WIDE_BITS'(HALVE ? (sum_i >>> 1) : sum_i), c_sd[1]);
    d2_d.r = sat_fp(WIDE_BITS'(HALVE ? (dif_r >>> 1) : dif_r), c_sd[2]);
    d2_d.i = sat_fp(WIDE_BITS'(HALVE ? (dif_i >>> 1) : dif_i), c_sd[3]);
    cw2_d  = cplx_conj(w1, c_cw);
    s2_clamp = (|c_sd) || c_cw;
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s2  <= s2_d;
      d2  <= d2_d;
      cw2 <= cw2_d;
      s3  <= s2;
    end
  end

  // conj(W) is already registered, so the multiplier does a plain product.
  cplx_mul_wide u_mul (
    .clk    (clk),
    .en     (adv),
    .conj_b (1'b0),
    .a      (d2),
    .b      (cw2),
    .p_r    (p3_r),
    .p_i    (p3_i)
  );

  logic signed [WIDE_BITS-1:0] t_r, t_i;
  complex_t b4_d;
  logic [1:0] c_t;
  logic       s4_clamp;

  always_comb begin
    c_t = 2'b00;
    t_r = p3_r >>> FRAC_BITS;
    t_i = p3_i >>> FRAC_BITS;
    if (SATURATE) begin
      b4_d.r = sat_fp(t_r, c_t[0]);
      b4_d.i = sat_fp(t_i, c_t[1]);
    end else begin
      b4_d.r = t_r[FP_BITS-1:0];
      b4_d.i = t_i[FP_BITS-1:0];
    end
    s4_clamp = |c_t;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a4  <= '0;
      b4  <= '0;
      ovf <= 1'b0;
    end else begin
      if (adv) begin
        a4 <= s3;
        b4 <= b4_d;
      end
      // A new clamp wins over a simultaneous clear.
      ovf <= (ovf && !ovf_clr) || (adv && ((v1 && s2_clamp) || (v3 && s4_clamp)));
    end
  end

endmodule
